// File: rtl/sram_bank_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM bank arbiter.
package sram_arb_pkg;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_CORE = 1'b1
    } req_e;

    localparam int MODE_RR        = 0;
    localparam int MODE_CORE_PRIO = 1;

    localparam int CNT_W = 16;

    // A single bank still needs a one-bit index so the bank ports never collapse to zero width.
    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Request/return bus between host/core requesters and the arbiter, plus the SRAM macro side.
interface sram_bank_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
);
    localparam int BW = bank_idx_w(NUM_BANKS);

    logic                          host_req;
    logic                          host_we;
    logic [BW-1:0]                 host_bank;
    logic [ADDR_W-1:0]             host_addr;
    logic [DATA_W-1:0]             host_wdata;
    logic                          host_gnt;
    logic                          host_rvalid;
    logic [DATA_W-1:0]             host_rdata;

    logic                          core_req;
    logic                          core_we;
    logic [BW-1:0]                 core_bank;
    logic [ADDR_W-1:0]             core_addr;
    logic [DATA_W-1:0]             core_wdata;
    logic                          core_gnt;
    logic                          core_rvalid;
    logic [DATA_W-1:0]             core_rdata;

    logic [NUM_BANKS-1:0]          sram_csb;
    logic [NUM_BANKS-1:0]          sram_web;
    logic [NUM_BANKS*ADDR_W-1:0]   sram_addr;
    logic [NUM_BANKS*DATA_W-1:0]   sram_din;
    logic [NUM_BANKS*DATA_W-1:0]   sram_dout;

    logic [CNT_W-1:0]              conflict_cnt;
    logic                          cnt_clr;

    modport master (
        output host_req, host_we, host_bank, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        output core_req, core_we, core_bank, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        input  sram_csb, sram_web, sram_addr, sram_din,
        output sram_dout,
        input  conflict_cnt,
        output cnt_clr
    );

    modport slave (
        input  host_req, host_we, host_bank, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        input  core_req, core_we, core_bank, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        output sram_csb, sram_web, sram_addr, sram_din,
        input  sram_dout,
        output conflict_cnt,
        input  cnt_clr
    );

endinterface

// File: rtl/sram_bank_arbiter_bank_port.sv
// One SRAM bank: picks a winner between host and core and registers the macro controls.
module sram_bank_port
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_RR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              core_sel,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              host_win,
    output logic              core_win,
    output logic              csb,
    output logic              web,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din
);

    req_e ptr;
    logic contested;

    assign contested = host_sel && core_sel;

    // Uncontested requests win outright; on contention core wins in priority mode, otherwise the pointer decides.
    always_comb begin
        host_win = host_sel;
        core_win = core_sel;
        if (contested) begin
            if ((MODE == MODE_CORE_PRIO) || (ptr == REQ_CORE)) begin
                host_win = 1'b0;
                core_win = 1'b1;
            end else begin
                host_win = 1'b1;
                core_win = 1'b0;
            end
        end
    end

    // Load the macro controls for the winner and flip the round-robin pointer only after a contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= REQ_HOST;
            csb  <= 1'b1;
            web  <= 1'b1;
            addr <= '0;
            din  <= '0;
        end else begin
            if (contested && (MODE == MODE_RR)) begin
                ptr <= (ptr == REQ_HOST) ? REQ_CORE : REQ_HOST;
            end
            if (host_win) begin
                csb  <= 1'b0;
                web  <= ~host_we;
                addr <= host_addr;
                if (host_we) begin
                    din <= host_wdata;
                end
            end else if (core_win) begin
                csb  <= 1'b0;
                web  <= ~core_we;
                addr <= core_addr;
                if (core_we) begin
                    din <= core_wdata;
                end
            end else begin
                csb <= 1'b1;
                web <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares NUM_BANKS sky130 SRAM macros between host and core with fixed two-cycle read return.
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int MODE      = MODE_RR
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    sram_bank_arbiter_if.slave  bus
);

    localparam int BW = bank_idx_w(NUM_BANKS);

    logic [NUM_BANKS-1:0] host_sel;
    logic [NUM_BANKS-1:0] core_sel;
    logic [NUM_BANKS-1:0] host_win;
    logic [NUM_BANKS-1:0] core_win;
    logic [DATA_W-1:0]    dout_arr [NUM_BANKS];

    logic                 host_gnt;
    logic                 core_gnt;
    logic                 conflict;

    logic                 host_v1;
    logic                 host_v2;
    logic [BW-1:0]        host_b1;
    logic [BW-1:0]        host_b2;
    logic                 core_v1;
    logic                 core_v2;
    logic [BW-1:0]        core_b1;
    logic [BW-1:0]        core_b2;

    logic [CNT_W-1:0]     conflict_cnt;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign host_sel[b] = bus.host_req && (bus.host_bank == BW'(b));
            assign core_sel[b] = bus.core_req && (bus.core_bank == BW'(b));
            assign dout_arr[b] = bus.sram_dout[b*DATA_W +: DATA_W];

            sram_bank_port #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W),
                .MODE   (MODE)
            ) u_port (
                .clk        (wb_clk_i),
                .rst        (wb_rst_i),
                .host_sel   (host_sel[b]),
                .host_we    (bus.host_we),
                .host_addr  (bus.host_addr),
                .host_wdata (bus.host_wdata),
                .core_sel   (core_sel[b]),
                .core_we    (bus.core_we),
                .core_addr  (bus.core_addr),
                .core_wdata (bus.core_wdata),
                .host_win   (host_win[b]),
                .core_win   (core_win[b]),
                .csb        (bus.sram_csb[b]),
                .web        (bus.sram_web[b]),
                .addr       (bus.sram_addr[b*ADDR_W +: ADDR_W]),
                .din        (bus.sram_din[b*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // A bank index outside the populated range matches no bank port, so it is never granted.
    assign host_gnt = (|host_win) && !wb_rst_i;
    assign core_gnt = (|core_win) && !wb_rst_i;
    assign conflict = (bus.host_req && !host_gnt) || (bus.core_req && !core_gnt);

    assign bus.host_gnt = host_gnt;
    assign bus.core_gnt = core_gnt;

    // Track each outstanding read for two cycles so its bank's macro output can be steered back.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            host_v1 <= 1'b0;
            host_v2 <= 1'b0;
            host_b1 <= '0;
            host_b2 <= '0;
            core_v1 <= 1'b0;
            core_v2 <= 1'b0;
            core_b1 <= '0;
            core_b2 <= '0;
        end else begin
            host_v1 <= host_gnt && !bus.host_we;
            host_b1 <= bus.host_bank;
            host_v2 <= host_v1;
            host_b2 <= host_b1;
            core_v1 <= core_gnt && !bus.core_we;
            core_b1 <= bus.core_bank;
            core_v2 <= core_v1;
            core_b2 <= core_b1;
        end
    end

    assign bus.host_rvalid = host_v2;
    assign bus.core_rvalid = core_v2;
    assign bus.host_rdata  = host_v2 ? dout_arr[host_b2] : '0;
    assign bus.core_rdata  = core_v2 ? dout_arr[core_b2] : '0;

    // Count refused-request cycles, saturating at all ones; a clear takes precedence over counting.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            conflict_cnt <= '0;
        end else if (bus.cnt_clr) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: a round-robin and a core-priority instance see identical stimulus.
module tb_sram_bank_arbiter;
    import sram_arb_pkg::*;

    localparam int NB = 3;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit h_req, h_we, c_req, c_we, clr;
    int h_bank, h_addr, h_data, c_bank, c_addr, c_data;

    logic [DW-1:0] gold [2][NB][1024];
    bit            turn [2][NB];
    int unsigned   mcnt [2];
    bit            exp_hv [2][4];
    bit            exp_cv [2][4];
    logic [DW-1:0] exp_hd [2][4];
    logic [DW-1:0] exp_cd [2][4];

    logic [DW-1:0]    mem_a [NB][1024];
    logic [DW-1:0]    mem_b [NB][1024];
    logic [NB*DW-1:0] dout_a = '0;
    logic [NB*DW-1:0] dout_b = '0;

    sram_bank_arbiter_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    sram_bank_arbiter_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    sram_bank_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .MODE(MODE_RR)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_a)
    );

    sram_bank_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .MODE(MODE_CORE_PRIO)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_b)
    );

    assign bus_a.sram_dout = dout_a;
    assign bus_b.sram_dout = dout_b;

    always #5 clk = ~clk;

    // Start both macro models from a known all-zero content.
    initial begin
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < 1024; a++) begin
                mem_a[b][a] = '0;
                mem_b[b][a] = '0;
            end
        end
    end

    // Behavioural 1RW macro: samples the registered controls at each rising edge.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bus_a.sram_csb[b] == 1'b0) begin
                if (bus_a.sram_web[b] == 1'b0) mem_a[b][bus_a.sram_addr[b*AW +: AW]] <= bus_a.sram_din[b*DW +: DW];
                else dout_a[b*DW +: DW] <= mem_a[b][bus_a.sram_addr[b*AW +: AW]];
            end
            if (bus_b.sram_csb[b] == 1'b0) begin
                if (bus_b.sram_web[b] == 1'b0) mem_b[b][bus_b.sram_addr[b*AW +: AW]] <= bus_b.sram_din[b*DW +: DW];
                else dout_b[b*DW +: DW] <= mem_b[b][bus_b.sram_addr[b*AW +: AW]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit hr, input bit hw, input int hb, input int ha, input int hd,
                                 input bit cr, input bit cw, input int cb, input int ca, input int cd);
        h_req = hr; h_we = hw; h_bank = hb; h_addr = ha; h_data = hd;
        c_req = cr; c_we = cw; c_bank = cb; c_addr = ca; c_data = cd;
        bus_a.host_req = hr; bus_a.host_we = hw; bus_a.host_bank = BW'(hb);
        bus_a.host_addr = AW'(ha); bus_a.host_wdata = DW'(hd);
        bus_a.core_req = cr; bus_a.core_we = cw; bus_a.core_bank = BW'(cb);
        bus_a.core_addr = AW'(ca); bus_a.core_wdata = DW'(cd);
        bus_a.cnt_clr = clr;
        bus_b.host_req = hr; bus_b.host_we = hw; bus_b.host_bank = BW'(hb);
        bus_b.host_addr = AW'(ha); bus_b.host_wdata = DW'(hd);
        bus_b.core_req = cr; bus_b.core_we = cw; bus_b.core_bank = BW'(cb);
        bus_b.core_addr = AW'(ca); bus_b.core_wdata = DW'(cd);
        bus_b.cnt_clr = clr;
        #1;
    endtask

    // Reference grant rule: distinct valid banks both win; a shared bank goes to core (m=1) or to whoever's turn it is (m=0).
    task automatic modelGrant(input int m, output bit hg, output bit cg);
        bit hv, cv;
        hv = h_req && (h_bank < NB);
        cv = c_req && (c_bank < NB);
        hg = 1'b0;
        cg = 1'b0;
        if (rst !== 1'b0) return;
        if (hv && cv && (h_bank == c_bank)) begin
            if (m == 1 || turn[m][h_bank]) cg = 1'b1;
            else hg = 1'b1;
        end else begin
            hg = hv;
            cg = cv;
        end
    endtask

    // Advance the reference model by one clock and move to the next sampling point.
    task automatic endCycle();
        bit hg, cg;
        int now_s, ret_s;
        now_s = cyc % 4;
        ret_s = (cyc + 2) % 4;
        for (int m = 0; m < 2; m++) begin
            modelGrant(m, hg, cg);
            exp_hv[m][now_s] = 1'b0;
            exp_cv[m][now_s] = 1'b0;
            if (rst !== 1'b0) begin
                for (int b = 0; b < NB; b++) turn[m][b] = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    exp_hv[m][s] = 1'b0;
                    exp_cv[m][s] = 1'b0;
                end
                mcnt[m] = 0;
            end else begin
                if (hg && !h_we) begin
                    exp_hv[m][ret_s] = 1'b1;
                    exp_hd[m][ret_s] = gold[m][h_bank][h_addr];
                end
                if (cg && !c_we) begin
                    exp_cv[m][ret_s] = 1'b1;
                    exp_cd[m][ret_s] = gold[m][c_bank][c_addr];
                end
                if (hg && h_we) gold[m][h_bank][h_addr] = DW'(h_data);
                if (cg && c_we) gold[m][c_bank][c_addr] = DW'(c_data);
                if (m == 0 && h_req && c_req && h_bank == c_bank && h_bank < NB) turn[m][h_bank] = !turn[m][h_bank];
                if (clr) mcnt[m] = 0;
                else if (((h_req && !hg) || (c_req && !cg)) && mcnt[m] < 32'hFFFF) mcnt[m]++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic checkModel();
        bit hg, cg;
        int s;
        s = cyc % 4;
        for (int m = 0; m < 2; m++) begin
            modelGrant(m, hg, cg);
            checkOutput($sformatf("m%0d_host_gnt@%0d", m, cyc), 32'(m == 0 ? bus_a.host_gnt : bus_b.host_gnt), 32'(hg));
            checkOutput($sformatf("m%0d_core_gnt@%0d", m, cyc), 32'(m == 0 ? bus_a.core_gnt : bus_b.core_gnt), 32'(cg));
            checkOutput($sformatf("m%0d_host_rvalid@%0d", m, cyc), 32'(m == 0 ? bus_a.host_rvalid : bus_b.host_rvalid), 32'(exp_hv[m][s]));
            checkOutput($sformatf("m%0d_core_rvalid@%0d", m, cyc), 32'(m == 0 ? bus_a.core_rvalid : bus_b.core_rvalid), 32'(exp_cv[m][s]));
            if (exp_hv[m][s])
                checkOutput($sformatf("m%0d_host_rdata@%0d", m, cyc), 32'(m == 0 ? bus_a.host_rdata : bus_b.host_rdata), 32'(exp_hd[m][s]));
            if (exp_cv[m][s])
                checkOutput($sformatf("m%0d_core_rdata@%0d", m, cyc), 32'(m == 0 ? bus_a.core_rdata : bus_b.core_rdata), 32'(exp_cd[m][s]));
            checkOutput($sformatf("m%0d_conflict_cnt@%0d", m, cyc), 32'(m == 0 ? bus_a.conflict_cnt : bus_b.conflict_cnt), mcnt[m]);
        end
    endtask

    // Directed scenarios first (they rely on fresh pointers), then random traffic, then counter saturation.
    initial begin
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            for (int b = 0; b < NB; b++) begin
                turn[m][b] = 1'b0;
                for (int a = 0; a < 1024; a++) gold[m][b][a] = '0;
            end
            for (int s = 0; s < 4; s++) begin
                exp_hv[m][s] = 1'b0;
                exp_cv[m][s] = 1'b0;
                exp_hd[m][s] = '0;
                exp_cd[m][s] = '0;
            end
        end
        rst = 1'b1;
        clr = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endCycle();
        endCycle();

        // Reset state, with a host request that must stay ungranted
        applyStimulus(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_host_gnt_a", 32'(bus_a.host_gnt), 0);
        checkOutput("rst_host_gnt_b", 32'(bus_b.host_gnt), 0);
        checkOutput("rst_csb", 32'(bus_a.sram_csb), 32'h7);
        checkOutput("rst_web", 32'(bus_a.sram_web), 32'h7);
        checkOutput("rst_addr", 32'(bus_a.sram_addr), 0);
        checkOutput("rst_din", 32'(bus_a.sram_din), 0);
        checkOutput("rst_cnt", 32'(bus_a.conflict_cnt), 0);
        checkOutput("rst_rvalid", 32'(bus_a.host_rvalid), 0);
        endCycle();

        // First cycle after release: host writes bank0, core writes bank1
        rst = 1'b0;
        applyStimulus(1, 1, 0, 5, 8'hA5, 1, 1, 1, 3, 8'h3C);
        checkOutput("wr_host_gnt_a", 32'(bus_a.host_gnt), 1);
        checkOutput("wr_core_gnt_a", 32'(bus_a.core_gnt), 1);
        checkOutput("wr_host_gnt_b", 32'(bus_b.host_gnt), 1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_csb0", 32'(bus_a.sram_csb[0]), 0);
        checkOutput("wr_web0", 32'(bus_a.sram_web[0]), 0);
        checkOutput("wr_addr0", 32'(bus_a.sram_addr[0 +: AW]), 5);
        checkOutput("wr_din0", 32'(bus_a.sram_din[0 +: DW]), 32'hA5);
        checkOutput("wr_csb1", 32'(bus_a.sram_csb[1]), 0);
        checkOutput("wr_din1", 32'(bus_a.sram_din[DW +: DW]), 32'h3C);
        endCycle();

        // Parallel reads to different banks
        applyStimulus(1, 0, 0, 5, 0, 1, 0, 1, 3, 0);
        checkOutput("rd_host_gnt", 32'(bus_a.host_gnt), 1);
        checkOutput("rd_core_gnt", 32'(bus_a.core_gnt), 1);
        checkOutput("idle_csb", 32'(bus_a.sram_csb), 32'h7);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_early_rvalid", 32'(bus_a.host_rvalid), 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_host_rvalid", 32'(bus_a.host_rvalid), 1);
        checkOutput("rd_host_rdata", 32'(bus_a.host_rdata), 32'hA5);
        checkOutput("rd_core_rvalid", 32'(bus_a.core_rvalid), 1);
        checkOutput("rd_core_rdata", 32'(bus_a.core_rdata), 32'h3C);
        checkOutput("rd_host_rdata_b", 32'(bus_b.host_rdata), 32'hA5);
        checkOutput("rd_cnt", 32'(bus_a.conflict_cnt), 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_rvalid_pulse", 32'(bus_a.host_rvalid), 0);
        endCycle();

        // Four contested cycles on bank1
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 3, 0, 1, 0, 1, 3, 0);
            checkOutput($sformatf("rr_host_gnt_%0d", i), 32'(bus_a.host_gnt), 32'(i % 2 == 0));
            checkOutput($sformatf("rr_core_gnt_%0d", i), 32'(bus_a.core_gnt), 32'(i % 2 == 1));
            checkOutput($sformatf("prio_host_gnt_%0d", i), 32'(bus_b.host_gnt), 0);
            checkOutput($sformatf("prio_core_gnt_%0d", i), 32'(bus_b.core_gnt), 1);
            endCycle();
        end
        applyStimulus(1, 0, 1, 3, 0, 1, 0, 1, 3, 0);
        checkOutput("rr_cnt4", 32'(bus_a.conflict_cnt), 4);
        checkOutput("prio_cnt4", 32'(bus_b.conflict_cnt), 4);
        checkOutput("rr_host_gnt_4", 32'(bus_a.host_gnt), 1);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endCycle();
        end

        // Reset right after a read grant: the read never returns and the pointer is back to host-first
        applyStimulus(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("kill_host_gnt", 32'(bus_a.host_gnt), 1);
        endCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("kill_csb_async", 32'(bus_a.sram_csb), 32'h7);
        checkOutput("kill_csb_async_b", 32'(bus_b.sram_csb), 32'h7);
        endCycle();
        rst = 1'b0;
        applyStimulus(1, 0, 0, 5, 0, 1, 0, 0, 5, 0);
        checkOutput("kill_rvalid_a", 32'(bus_a.host_rvalid), 0);
        checkOutput("kill_rvalid_b", 32'(bus_b.host_rvalid), 0);
        checkOutput("kill_cnt", 32'(bus_a.conflict_cnt), 0);
        checkOutput("post_rst_host_gnt", 32'(bus_a.host_gnt), 1);
        checkOutput("post_rst_core_gnt", 32'(bus_a.core_gnt), 0);
        endCycle();

        // Random traffic against the reference model, including out-of-range bank 3
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 49) == 0);
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            checkModel();
            endCycle();
        end
        clr = 1'b0;

        // Saturate the counter with a host request to a nonexistent bank
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) endCycle();
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_cnt_a", 32'(bus_a.conflict_cnt), 32'hFFFF);
        checkOutput("sat_cnt_b", 32'(bus_b.conflict_cnt), 32'hFFFF);
        checkOutput("oor_host_gnt", 32'(bus_a.host_gnt), 0);
        endCycle();
        clr = 1'b1;
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_hold", 32'(bus_a.conflict_cnt), 32'hFFFF);
        endCycle();
        clr = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("clr_cnt_a", 32'(bus_a.conflict_cnt), 0);
        checkOutput("clr_cnt_b", 32'(bus_b.conflict_cnt), 0);
        checkModel();
        endCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
